// File: rtl/alu_pkg.sv
// Shared types for the shared-ALU arbiter: opcode encoding, flag layout,
// and sequencer states.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [3:0] {
    ALUC_ADD  = 4'd0,
    ALUC_SUB  = 4'd1,
    ALUC_AND  = 4'd2,
    ALUC_OR   = 4'd3,
    ALUC_XOR  = 4'd4,
    ALUC_SLT  = 4'd5,
    ALUC_SLTU = 4'd6,
    ALUC_SLL  = 4'd7,
    ALUC_SRL  = 4'd8,
    ALUC_SRA  = 4'd9
  } aluc_e;

  localparam logic [3:0] ALUC_MAX = 4'd9;

  // Packed so the struct reads as a 4-bit {zero, cout, overflow, sign} vector.
  typedef struct packed {
    logic zero;
    logic cout;
    logic overflow;
    logic sign;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Requester identity, also used as the round-robin pointer value.
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  function automatic logic aluc_illegal(input logic [3:0] aluc);
    return aluc > ALUC_MAX;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. cout is the carry out of the adder (for SUB it is
// the carry of a + ~b + 1, i.e. 1 means no borrow); overflow is signed
// overflow for ADD/SUB; both are 0 for every other opcode.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  input  logic [3:0]       aluc_i,
  output logic [ALU_W-1:0] out_o,
  output alu_flags_t       flags_o
);

  logic [ALU_W:0]   sum;
  logic [ALU_W-1:0] res;
  logic             cout;
  logic             ovf;

  // Operation select and flag generation.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    sum  = '0;
    res  = '0;
    cout = 1'b0;
    ovf  = 1'b0;
    case (aluc_i)
      ALUC_ADD: begin
        sum  = {1'b0, a_i} + {1'b0, b_i};
        res  = sum[ALU_W-1:0];
        cout = sum[ALU_W];
        ovf  = (a_i[ALU_W-1] == b_i[ALU_W-1]) && (res[ALU_W-1] != a_i[ALU_W-1]);
      end
      ALUC_SUB: begin
        sum  = {1'b0, a_i} + {1'b0, ~b_i} + {{ALU_W{1'b0}}, 1'b1};
        res  = sum[ALU_W-1:0];
        cout = sum[ALU_W];
        ovf  = (a_i[ALU_W-1] != b_i[ALU_W-1]) && (res[ALU_W-1] != a_i[ALU_W-1]);
      end
      ALUC_AND:  res = a_i & b_i;
      ALUC_OR:   res = a_i | b_i;
      ALUC_XOR:  res = a_i ^ b_i;
      ALUC_SLT:  res = {{(ALU_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALUC_SLTU: res = {{(ALU_W-1){1'b0}}, (a_i < b_i)};
      ALUC_SLL:  res = a_i << b_i[4:0];
      ALUC_SRL:  res = a_i >> b_i[4:0];
      ALUC_SRA:  res = $unsigned($signed(a_i) >>> b_i[4:0]);
      default:   res = '0;
    endcase
  end

  assign out_o            = res;
  assign flags_o.zero     = (res == '0);
  assign flags_o.cout     = cout;
  assign flags_o.overflow = ovf;
  assign flags_o.sign     = res[ALU_W-1];

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between requesters A and B with round-robin arbitration and
// an IDLE -> EXEC -> RESP sequencer; the response carries the requester ID.
// Optional macro ALU_ARB_STATS_EN adds saturating grant/stall counters.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_src1,
  input  logic [DATA_W-1:0] a_src2,
  input  logic [3:0]        a_aluc,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_src1,
  input  logic [DATA_W-1:0] b_src2,
  input  logic [3:0]        b_aluc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_out,
  output logic [3:0]        rsp_flags,
  output logic              rsp_err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_grant_a,
  output logic [CNT_W-1:0]  stat_grant_b,
  output logic [CNT_W-1:0]  stat_stall
`endif
);

  if (DATA_W != ALU_W || CNT_W < 1) begin : g_param_check
    $error("alu_share_arb: DATA_W must equal 32 and CNT_W must be positive");
  end

  arb_state_e        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
  logic [3:0]        aluc_q, aluc_d;
  logic              id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_out_q, rsp_out_d;
  alu_flags_t        rsp_flags_q, rsp_flags_d;
  logic              rsp_err_q, rsp_err_d;
  logic              gnt_a, gnt_b;
  logic [DATA_W-1:0] alu_out;
  alu_flags_t        alu_flags;

  // The ALU always sees the latched operands; idle values are harmless.
  alu u_alu (
    .a_i     (src1_q),
    .b_i     (src2_q),
    .aluc_i  (aluc_q),
    .out_o   (alu_out),
    .flags_o (alu_flags)
  );

  // Round-robin grant: only in IDLE, sole requester wins, pointer breaks ties.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state_q == ST_IDLE) begin
      gnt_a = a_valid && (!b_valid || ptr_q == ID_A);
      gnt_b = b_valid && (!a_valid || ptr_q == ID_B);
    end
  end

  assign a_ready = gnt_a;
  assign b_ready = gnt_b;

  // Sequencer next-state: accept in IDLE, capture in EXEC, hand off in RESP.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    aluc_d      = aluc_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_a) begin
          src1_d  = a_src1;
          src2_d  = a_src2;
          aluc_d  = a_aluc;
          id_d    = ID_A;
          state_d = ST_EXEC;
        end else if (gnt_b) begin
          src1_d  = b_src1;
          src2_d  = b_src2;
          aluc_d  = b_aluc;
          id_d    = ID_B;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_err_d   = aluc_illegal(aluc_q);
        rsp_out_d   = rsp_err_d ? '0 : alu_out;
        rsp_flags_d = rsp_err_d ? '0 : alu_flags;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Pointer moves only when a response completes, to the other side.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = ~rsp_id_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: operand registers are reset too, so the idle ALU input is a known value.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= ID_A;
      src1_q      <= '0;
      src2_q      <= '0;
      aluc_q      <= '0;
      id_q        <= ID_A;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_out_q   <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      aluc_q      <= aluc_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_flags = rsp_flags_q;
  assign rsp_err   = rsp_err_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] stat_grant_a_q, stat_grant_b_q, stat_stall_q;
  logic             stall;

  assign stall = (a_valid || b_valid) && !(gnt_a || gnt_b);

  // Saturating statistics counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grant_a_q <= '0;
      stat_grant_b_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      if (gnt_a && stat_grant_a_q != '1) stat_grant_a_q <= stat_grant_a_q + CNT_W'(1);
      if (gnt_b && stat_grant_b_q != '1) stat_grant_b_q <= stat_grant_b_q + CNT_W'(1);
      if (stall && stat_stall_q   != '1) stat_stall_q   <= stat_stall_q + CNT_W'(1);
    end
  end

  assign stat_grant_a = stat_grant_a_q;
  assign stat_grant_b = stat_grant_b_q;
  assign stat_stall   = stat_stall_q;
`endif

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Shares one combinational 32-bit ALU between two requesters, A and B.
- Each requester has a valid/ready request channel. Both share one valid/ready response channel whose responses carry an ID.
- A 3-state FSM sequences each operation: accept, execute, respond.
- Round-robin arbitration between A and B. Result and flags are registered.
- Sits between the execute/address-generation front ends and the ALU, which is instantiated inside this block.

Parameters:
- DATA_W, 32: operand/result width. Fixed by the ALU; only 32 is legal.
- CNT_W, 16: width of the statistics counters. Used only with ALU_ARB_STATS_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  requester A has an op pending
- a_ready  out  1  A request accepted this cycle
- a_src1, a_src2  in  32  A operands
- a_aluc  in  4  A opcode (alu_pkg codes)
- b_valid, b_ready, b_src1, b_src2, b_aluc: same as A, for requester B
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes the result
- rsp_id  out  1  0=A, 1=B
- rsp_out  out  32  ALU result
- rsp_flags  out  4  {zero, cout, overflow, sign}
- rsp_err  out  1  opcode was illegal (>4'd9)
- stat_grant_a, stat_grant_b, stat_stall  out  CNT_W  statistics; present only with ALU_ARB_STATS_EN

Behaviour:
- Reset (async assert, sync-free deassert):
  - state=IDLE; a_ready=b_ready=0; rsp_valid=0; rsp_id=0; rsp_out=0; rsp_flags=0; rsp_err=0.
  - Operand/opcode registers=0. Priority pointer = A.
- Reset mid-operation: the in-flight op is dropped silently and no response is issued.
- ready is combinational from state and valid. It is high only in IDLE, for the single winner. Never assert a_ready and b_ready in the same cycle.
- IDLE:
  - If only one valid: grant it.
  - If both valid: grant the pointer side.
  - On grant (valid&&ready): latch src1, src2, aluc and the ID; go to EXEC.
  - If no valid: stay in IDLE.
- EXEC:
  - The ALU is driven from the latched registers.
  - At the clock edge, capture out and flags into the rsp_* registers and set rsp_err=(aluc>9).
  - If aluc>9: force rsp_out=0 and rsp_flags=0.
  - Set rsp_valid=1; go to RESP.
- RESP:
  - Hold all rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid=0 next cycle; priority pointer set to the side not just served; go to IDLE.
- Latency: handshake at edge N → rsp_valid high after edge N+1. Minimum 3 cycles per op; no new accept while in EXEC or RESP.
- A requester must hold valid and operands stable until ready. Dropping valid before grant is permitted; the request is simply not served.
- The pointer changes only on response completion, never on a bare grant. Under continuous requests from both sides, service alternates A, B, A, B.
- The ALU inputs keep the last latched operands while idle; this is harmless because the ALU is combinational.
- Flag semantics are exactly those of the ALU's zero, cout, overflow and sign outputs.

Optional Feature:
- Macro ALU_ARB_STATS_EN. When defined, three CNT_W saturating counters are present, all reset to 0:
  - stat_grant_a: +1 per A grant.
  - stat_grant_b: +1 per B grant.
  - stat_stall: +1 per cycle in which some valid is high but no ready is asserted.
- Counters saturate at all-ones and do not wrap.
- Without the macro: the stat_* ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - ALU_W=32.
  - aluc enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9.
  - ALUC_MAX=9.
  - Packed flags struct {zero, cout, overflow, sign}.
  - FSM state enum {IDLE, EXEC, RESP}.
- Single sub-module: the existing alu, instantiated once. Arbitration and FSM are inline.

Test Plan:
- A only: src1=15, src2=10, aluc=0 → a_ready 1 cycle; 2 edges later rsp_valid=1, rsp_id=0, rsp_out=25, flags zero=0; b_ready stays 0.
- A and B both valid from reset:
  - A: 20−10, SUB.
  - B: 0xFF00FF00 & 0x0F0F0F0F, AND.
  - Expect A served first (rsp_out=10, id 0), then B (rsp_out=0x0F000F00, id 1).
  - Keep both asserted for 4 ops → ids 0,1,0,1.
- Response backpressure: rsp_ready=0 for 5 cycles with B SLT (−5, 2) pending → rsp_out=1, id 1 held stable, no new ready; release → IDLE next cycle.
- Illegal opcode: A aluc=4'hC, src1=3, src2=4 → rsp_err=1, rsp_out=0, rsp_flags=0. A following A ADD 1+1 → rsp_err=0, rsp_out=2.
- Reset mid-op: assert rst_n=0 while in RESP with SRA (−4, 1) pending → rsp_valid drops immediately, outputs 0. After release, a B request is granted first (pointer=A, but A is idle).
- ALU_ARB_STATS_EN: run the contention test → stat_grant_a=2, stat_grant_b=2, stat_stall equals the counted stall cycles. Preload near saturation and confirm the counter holds at 0xFFFF.
